// File: rtl/pc_redirect_ctrl.sv
// Next-PC sequencer: owns the fetch PC, arbitrates branch/jump/sequential
// sources, holds jumps that arrive during a stall, and counts redirects/squashes.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             jmp_req,
  input  logic [31:0]      jmp_target,
  output logic [31:0]      pc,
  output logic             fetch_valid,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_target_q, pend_target_d;
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic [1:0]       redirect_inc_s;
  logic [1:0]       squash_inc_s;
  logic             flush_if_id_s;
  logic             flush_id_ex_s;

  // Saturating add: a +2 from max-1 clamps to all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  // Next-state, next-PC, flush strobes and counter increments
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pend_target_d  = pend_target_q;
    redirect_inc_s = 2'd0;
    squash_inc_s   = 2'd0;
    flush_if_id_s  = 1'b0;
    flush_id_ex_s  = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (br_taken) begin
          pc_d           = br_target;
          flush_if_id_s  = 1'b1;
          flush_id_ex_s  = 1'b1;
          redirect_inc_s = 2'd1;
          squash_inc_s   = 2'd2;
        end else if (jmp_req && !stall) begin
          pc_d           = jmp_target;
          flush_if_id_s  = 1'b1;
          redirect_inc_s = 2'd1;
          squash_inc_s   = 2'd1;
        end else if (jmp_req) begin
          pend_target_d = jmp_target;
          state_d       = ST_PEND;
        end else if (!stall) begin
          pc_d = pc_q + 32'd1;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_PEND: begin
        // The branch is older than the held jump, so it wins and the jump dies.
        if (br_taken) begin
          pc_d           = br_target;
          pend_target_d  = 32'd0;
          flush_if_id_s  = 1'b1;
          flush_id_ex_s  = 1'b1;
          redirect_inc_s = 2'd1;
          squash_inc_s   = 2'd2;
          state_d        = ST_RUN;
        end else if (!stall) begin
          pc_d           = pend_target_q;
          flush_if_id_s  = 1'b1;
          redirect_inc_s = 2'd1;
          squash_inc_s   = 2'd1;
          state_d        = ST_RUN;
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    redirect_cnt_d = sat_add(redirect_cnt_q, redirect_inc_s);
    squash_cnt_d   = sat_add(squash_cnt_q, squash_inc_s);
    fetch_valid_d  = (state_d == ST_RUN);
  end

  // State, PC, pending target, counters and fetch_valid registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_BOOT;
      pc_q           <= RESET_PC;
      pend_target_q  <= 32'd0;
      redirect_cnt_q <= {CNT_W{1'b0}};
      squash_cnt_q   <= {CNT_W{1'b0}};
      fetch_valid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pend_target_q  <= pend_target_d;
      redirect_cnt_q <= redirect_cnt_d;
      squash_cnt_q   <= squash_cnt_d;
      fetch_valid_q  <= fetch_valid_d;
    end
  end

  assign pc           = pc_q;
  assign fetch_valid  = fetch_valid_q;
  assign flush_if_id  = flush_if_id_s;
  assign flush_id_ex  = flush_id_ex_s;
  assign redirect_cnt = redirect_cnt_q;
  assign squash_cnt   = squash_cnt_q;

endmodule
